fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Merges NCHANNELS independent FIFO write streams onto one downstream FIFO write port with round-robin arbitration. Each channel gets a 2-entry buffer, so per-channel `full` is registered and does not depend on the downstream `full`. The block sits between several producers (e.g. per-queue DMA engines) and one shared RX/TX data FIFO. It generalises a 1:1 write-interface pass-through to N:1 with buffering, fairness, overflow detection and an optional packet-atomic mode.

## Interface
Parameters:
- NCHANNELS, 4: number of producer channels; must be ≥2.
- DATA_WIDTH, 32: width of the write data word.
- COUNT_WIDTH, 10: width of the downstream `wr_data_count`.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_wr_en  in  NCHANNELS  per-channel write strobe.
- s_wr_data  in  NCHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_wr_last  in  NCHANNELS  end-of-packet marker; present only with FIFO_WRITE_ARB_PACKET_EN.
- s_full  out  NCHANNELS  channel buffer holds 2 entries.
- s_almost_full  out  NCHANNELS  channel buffer holds ≥1 entry.
- s_wr_data_count  out  COUNT_WIDTH  broadcast copy of m_wr_data_count.
- s_overflow  out  NCHANNELS  sticky: a write was attempted while s_full was high.
- m_wr_en  out  1  downstream write strobe.
- m_wr_data  out  DATA_WIDTH  downstream write data.
- m_full  in  1  downstream FIFO full.
- m_almost_full  in  1  downstream almost full; monitored only, does not gate writes.
- m_wr_data_count  in  COUNT_WIDTH  downstream fill level.

## Operation
- **Per-channel buffer:** a 2-entry FIFO holding data, plus the last bit in packet mode, with a 2-bit count cnt[i] in the range 0..2.
  - s_full[i] = (cnt[i]==2).
  - s_almost_full[i] = (cnt[i]!=0).
  - Both are decoded directly from registered counts.
- **Enqueue:** on s_wr_en[i] && !s_full[i].
  - s_wr_en[i] while s_full[i] is high drops the word and sets s_overflow[i].
  - s_overflow[i] clears only on reset.
- **Simultaneous enqueue and dequeue** on the same channel: cnt is unchanged and data order is preserved. This is legal at cnt 1, and also at cnt 2 only on the dequeue side.
- **Arbitration:** combinational each cycle. The request vector is req[i] = (cnt[i]!=0).
  - If !m_full and any req: grant the first requesting channel searching upward from ptr+1 modulo NCHANNELS.
  - Drive m_wr_en=1 and m_wr_data = that channel's head, and dequeue it in the same cycle.
  - On a grant, ptr <= granted index.
  - If m_full or no req: m_wr_en=0 and ptr holds.
- m_wr_data is don't-care when m_wr_en=0; drive the channel-0 head.
- s_wr_data_count = m_wr_data_count, combinational.
- **Reset (asynchronous, any time):**
  - cnt=0, buffers empty, ptr=NCHANNELS-1 (so channel 0 wins first), s_overflow=0, lock cleared.
  - Outputs during and after reset: s_full=0, s_almost_full=0, m_wr_en=0.
  - In-flight words are discarded.

## Timing
- Latency from s_wr_en at cycle t to m_wr_en: cycle t+1 at the earliest, when uncontended and m_full is low.
- Per-channel sustained throughput is 1 word/cycle when that channel is the only requester. The aggregate is 1 word/cycle.
- m_wr_en is combinational from registered state and m_full. The downstream FIFO must present a registered full.
- **Fairness:** with all channels continuously requesting, grants rotate 0,1,…,N-1,0…; each channel waits at most NCHANNELS-1 grants.
- m_full asserted: no dequeue in that cycle, and buffers fill to s_full within 2 writes per channel.

## Configuration
- **FIFO_WRITE_ARB_PACKET_EN defined:** packet-atomic mode.
  - s_wr_last exists and is stored with each entry.
  - After granting a beat with last=0, the arbiter locks to that channel. Only that channel is eligible until its last=1 beat is written.
  - If the locked channel is empty, m_wr_en=0 (bubble) and the lock holds.
  - ptr updates only on the last=1 beat.
- **Undefined:** s_wr_last is absent and arbitration is per-beat round-robin with no lock.

## Test plan
- **Single channel, back-to-back:** reset; ch2 writes 0xA0..0xA7 on consecutive cycles with m_full=0 → m_wr_en high at cycles 1..8 with data A0..A7 in order; s_full[2] never asserts.
- **Round-robin:** all 4 channels hold 2 words; m_full=0 → grant order ch0,1,2,3,0,1,2,3; ptr ends at 3.
- **Backpressure and overflow:** m_full=1; ch1 writes 3 words 0x11,0x12,0x13 → s_full[1]=1 after the second write; 0x13 is dropped and s_overflow[1]=1. Release m_full → 0x11,0x12 are output; s_overflow[1] stays 1.
- **Async reset mid-stream:** assert reset with cnt=2 on all channels → s_full, s_almost_full and m_wr_en are 0 immediately, without waiting for a clock edge. After release, the first grant goes to ch0.
- **Packet mode (macro defined):** ch0 sends a 3-beat packet with a 1-cycle gap before the last beat; ch1 has a pending beat → output is ch0 b0, b1, bubble, ch0 b2, then ch1.
- **Count broadcast:** drive m_wr_data_count=0x155 → s_wr_data_count=0x155 in the same cycle.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// N:1 round-robin merge of FIFO write streams, 2-entry buffer per channel.
// Define FIFO_WRITE_ARB_PACKET_EN for packet-atomic arbitration (adds s_wr_last).

module fifo_write_arb_chan #(
  parameter int EW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [EW-1:0] din,
  input  logic          pop,
  output logic [EW-1:0] head,
  output logic [1:0]    cnt,
  output logic          overflow
);
  logic [1:0][EW-1:0] mem;
  logic               wp, rp;
  logic               full, push;

  assign full = (cnt == 2'd2);
  // full comes from the registered count, so a pop in the same cycle never frees room
  assign push = wr_en && !full;
  assign head = mem[rp];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt      <= cnt + 2'(push) - 2'(pop);
      overflow <= overflow | (wr_en & full);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= din;
  end
endmodule

module fifo_write_arbiter #(
  parameter int NCHANNELS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NCHANNELS-1:0]            s_wr_en,
  input  logic [NCHANNELS*DATA_WIDTH-1:0] s_wr_data,
`ifdef FIFO_WRITE_ARB_PACKET_EN
  input  logic [NCHANNELS-1:0]            s_wr_last,
`endif
  output logic [NCHANNELS-1:0]            s_full,
  output logic [NCHANNELS-1:0]            s_almost_full,
  output logic [COUNT_WIDTH-1:0]          s_wr_data_count,
  output logic [NCHANNELS-1:0]            s_overflow,
  output logic                            m_wr_en,
  output logic [DATA_WIDTH-1:0]           m_wr_data,
  input  logic                            m_full,
  input  logic                            m_almost_full,
  input  logic [COUNT_WIDTH-1:0]          m_wr_data_count
);
  localparam int PW = $clog2(NCHANNELS);
`ifdef FIFO_WRITE_ARB_PACKET_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] idx;
  } grant_t;

  logic [NCHANNELS-1:0][EW-1:0] chan_din, heads;
  logic [NCHANNELS-1:0][1:0]    cnt;
  logic [NCHANNELS-1:0]         req, eligible, pop;
  logic [PW-1:0]                ptr, cand;
  grant_t                       gnt;
  logic                         unused_m_almost_full;

  assign unused_m_almost_full = m_almost_full;
  assign s_wr_data_count      = m_wr_data_count;

  for (genvar i = 0; i < NCHANNELS; i++) begin : g_ch
`ifdef FIFO_WRITE_ARB_PACKET_EN
    assign chan_din[i] = {s_wr_last[i], s_wr_data[i*DATA_WIDTH +: DATA_WIDTH]};
`else
    assign chan_din[i] = s_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    assign req[i]           = (cnt[i] != 2'd0);
    assign s_full[i]        = (cnt[i] == 2'd2);
    assign s_almost_full[i] = (cnt[i] != 2'd0);

    fifo_write_arb_chan #(.EW(EW)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (s_wr_en[i]),
      .din      (chan_din[i]),
      .pop      (pop[i]),
      .head     (heads[i]),
      .cnt      (cnt[i]),
      .overflow (s_overflow[i])
    );
  end

`ifdef FIFO_WRITE_ARB_PACKET_EN
  typedef enum logic { ARB_FREE, ARB_LOCKED } arb_state_t;
  arb_state_t    state;
  logic [PW-1:0] lock_ch;
  logic          head_last;

  always_comb begin
    eligible = req;
    if (state == ARB_LOCKED) begin
      eligible = '0;
      eligible[lock_ch] = req[lock_ch];
    end
  end
  assign head_last = heads[gnt.idx][DATA_WIDTH];
`else
  assign eligible = req;
`endif

  // Search upward from ptr+1 so the last winner has lowest priority
  always_comb begin
    gnt  = '0;
    cand = '0;
    if (!m_full) begin
      for (int k = 1; k <= NCHANNELS; k++) begin
        cand = PW'((int'(ptr) + k) % NCHANNELS);
        if (!gnt.vld && eligible[cand]) begin
          gnt.vld = 1'b1;
          gnt.idx = cand;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt.vld) pop[gnt.idx] = 1'b1;
  end

  // With no grant idx stays 0, so the channel-0 head is presented
  assign m_wr_en   = gnt.vld;
  assign m_wr_data = heads[gnt.idx][DATA_WIDTH-1:0];

`ifdef FIFO_WRITE_ARB_PACKET_EN
  // ptr moves only at packet end, so the lock holder keeps its turn position
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr     <= PW'(NCHANNELS - 1);
      state   <= ARB_FREE;
      lock_ch <= '0;
    end else if (gnt.vld) begin
      if (head_last) begin
        ptr   <= gnt.idx;
        state <= ARB_FREE;
      end else begin
        state   <= ARB_LOCKED;
        lock_ch <= gnt.idx;
      end
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ptr <= PW'(NCHANNELS - 1);
    else if (gnt.vld) ptr <= gnt.idx;
  end
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random checks of fifo_write_arbiter against a queue-based model.
module tb_fifo_write_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 10;

  logic                clock = 1'b0;
  logic                reset;
  logic [NCH-1:0]      s_wr_en, s_wr_last, s_full, s_almost_full, s_overflow;
  logic [NCH*DW-1:0]   s_wr_data;
  logic [CW-1:0]       s_wr_data_count, m_wr_data_count;
  logic                m_wr_en, m_full, m_almost_full;
  logic [DW-1:0]       m_wr_data;

  fifo_write_arbiter #(.NCHANNELS(NCH), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .s_wr_en         (s_wr_en),
    .s_wr_data       (s_wr_data),
`ifdef FIFO_WRITE_ARB_PACKET_EN
    .s_wr_last       (s_wr_last),
`endif
    .s_full          (s_full),
    .s_almost_full   (s_almost_full),
    .s_wr_data_count (s_wr_data_count),
    .s_overflow      (s_overflow),
    .m_wr_en         (m_wr_en),
    .m_wr_data       (m_wr_data),
    .m_full          (m_full),
    .m_almost_full   (m_almost_full),
    .m_wr_data_count (m_wr_data_count)
  );

  always #5 clock = ~clock;

  // Reference model: one queue of {last,data} per channel
  logic [DW:0]    mq [NCH][$];
  int             mptr;
  logic [NCH-1:0] movf;
  bit             mlock;
  int             mlock_ch;
  int             vectors = 0;
  int             miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mreset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    mptr     = NCH - 1;
    movf     = '0;
    mlock    = 1'b0;
    mlock_ch = 0;
  endfunction

  // Check all outputs mid-cycle, then advance the model across the clock edge
  task automatic cycle();
    int             g;
    logic [NCH-1:0] ef, ea;
    @(negedge clock);
    g = -1;
    if (!m_full)
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (mptr + k) % NCH;
        if (g < 0 && mq[c].size() != 0 && (!mlock || c == mlock_ch)) g = c;
      end
    for (int c = 0; c < NCH; c++) begin
      ef[c] = (mq[c].size() == 2);
      ea[c] = (mq[c].size() != 0);
    end
    chk("s_full", 64'(s_full), 64'(ef));
    chk("s_almost_full", 64'(s_almost_full), 64'(ea));
    chk("s_overflow", 64'(s_overflow), 64'(movf));
    chk("m_wr_en", 64'(m_wr_en), 64'(g >= 0));
    if (g >= 0) chk("m_wr_data", 64'(m_wr_data), 64'(mq[g][0][DW-1:0]));
    chk("s_wr_data_count", 64'(s_wr_data_count), 64'(m_wr_data_count));
    @(posedge clock);
    if (g >= 0) begin
      logic [DW:0] e;
      e = mq[g].pop_front();
      if (e[DW]) begin
        mptr  = g;
        mlock = 1'b0;
      end else begin
        mlock    = 1'b1;
        mlock_ch = g;
      end
    end
    for (int c = 0; c < NCH; c++)
      if (s_wr_en[c]) begin
        if (ef[c]) movf[c] = 1'b1;
        else mq[c].push_back({s_wr_last[c], s_wr_data[c*DW +: DW]});
      end
    #1;
  endtask

  task automatic do_reset();
    s_wr_en = '0;
    m_full  = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rst_s_full", 64'(s_full), 64'd0);
    chk("rst_s_almost_full", 64'(s_almost_full), 64'd0);
    chk("rst_m_wr_en", 64'(m_wr_en), 64'd0);
    chk("rst_s_overflow", 64'(s_overflow), 64'd0);
    mreset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    s_wr_en = '0; s_wr_last = '1; s_wr_data = '0;
    m_full = 1'b0; m_almost_full = 1'b0; m_wr_data_count = '0; reset = 1'b0;
    #2;
    do_reset();

    // single channel back-to-back: one cycle latency, never fills
    for (int k = 0; k < 8; k++) begin
      s_wr_en = 4'b0100;
      s_wr_data[2*DW +: DW] = 32'(32'hA0 + k);
      #1;
      if (k > 0) begin
        chk("t1_en", 64'(m_wr_en), 64'd1);
        chk("t1_data", 64'(m_wr_data), 64'(32'hA0 + k - 1));
      end
      cycle();
    end
    s_wr_en = '0;
    #1;
    chk("t1_last", 64'(m_wr_data), 64'hA7);
    cycle();
    chk("t1_idle", 64'(m_wr_en), 64'd0);

    // round-robin over full buffers
    do_reset();
    m_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_wr_en = '1;
      for (int c = 0; c < NCH; c++) s_wr_data[c*DW +: DW] = 32'(16*c + k);
      cycle();
    end
    s_wr_en = '0;
    m_full  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("t2_en", 64'(m_wr_en), 64'd1);
      chk("t2_order", 64'(m_wr_data), 64'(16*(n % NCH) + n / NCH));
      cycle();
    end
    s_wr_en = 4'b1001;
    s_wr_data[0 +: DW]    = 32'hC0;
    s_wr_data[3*DW +: DW] = 32'hC3;
    cycle();
    s_wr_en = '0;
    #1;
    chk("t2_ptr_end", 64'(m_wr_data), 64'hC0);
    cycle();
    cycle();

    // backpressure and overflow
    do_reset();
    m_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_wr_en = 4'b0010;
      s_wr_data[DW +: DW] = 32'(32'h11 + k);
      cycle();
      if (k == 0) chk("t3_almost", 64'(s_almost_full[1]), 64'd1);
      if (k == 1) chk("t3_full", 64'(s_full[1]), 64'd1);
      if (k == 2) chk("t3_ovf", 64'(s_overflow[1]), 64'd1);
    end
    s_wr_en = '0;
    m_full  = 1'b0;
    #1; chk("t3_out0", 64'(m_wr_data), 64'h11); cycle();
    #1; chk("t3_out1", 64'(m_wr_data), 64'h12); cycle();
    #1; chk("t3_drained", 64'(m_wr_en), 64'd0);
    chk("t3_ovf_sticky", 64'(s_overflow[1]), 64'd1);
    cycle();

    // asynchronous reset with every buffer full
    do_reset();
    m_full  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_wr_en = '1;
      for (int c = 0; c < NCH; c++) s_wr_data[c*DW +: DW] = $urandom;
      cycle();
    end
    s_wr_en = '0;
    m_full  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t4_full", 64'(s_full), 64'd0);
    chk("t4_almost", 64'(s_almost_full), 64'd0);
    chk("t4_en", 64'(m_wr_en), 64'd0);
    mreset();
    @(posedge clock);
    #1;
    reset   = 1'b0;
    s_wr_en = 4'b1001;
    s_wr_data[0 +: DW]    = 32'hD0;
    s_wr_data[3*DW +: DW] = 32'hD3;
    cycle();
    s_wr_en = '0;
    #1;
    chk("t4_first", 64'(m_wr_data), 64'hD0);
    cycle();
    cycle();

    // count broadcast
    m_wr_data_count = 10'h155;
    #1;
    chk("t5_count", 64'(s_wr_data_count), 64'h155);
    cycle();
    m_wr_data_count = '0;

`ifdef FIFO_WRITE_ARB_PACKET_EN
    // packet lock with a bubble before the last beat
    do_reset();
    s_wr_en = 4'b0011;
    s_wr_data[0 +: DW] = 32'hE0;  s_wr_last[0] = 1'b0;
    s_wr_data[DW +: DW] = 32'hF1; s_wr_last[1] = 1'b1;
    #1; chk("t6_s0", 64'(m_wr_en), 64'd0); cycle();
    s_wr_en = 4'b0001;
    s_wr_data[0 +: DW] = 32'hE1;
    #1; chk("t6_b0", 64'(m_wr_data), 64'hE0); cycle();
    s_wr_en = '0;
    #1; chk("t6_b1", 64'(m_wr_data), 64'hE1); cycle();
    s_wr_en = 4'b0001;
    s_wr_data[0 +: DW] = 32'hE2; s_wr_last[0] = 1'b1;
    #1; chk("t6_bubble", 64'(m_wr_en), 64'd0); cycle();
    s_wr_en = '0;
    #1; chk("t6_b2", 64'(m_wr_data), 64'hE2); cycle();
    #1; chk("t6_ch1", 64'(m_wr_data), 64'hF1); cycle();
    s_wr_last = '1;
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      s_wr_en = NCH'($urandom);
      for (int c = 0; c < NCH; c++) s_wr_data[c*DW +: DW] = $urandom;
`ifdef FIFO_WRITE_ARB_PACKET_EN
      for (int c = 0; c < NCH; c++) s_wr_last[c] = ($urandom_range(0, 2) != 0);
`endif
      m_full          = ($urandom_range(0, 3) == 0);
      m_almost_full   = 1'($urandom);
      m_wr_data_count = CW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
